// File: rtl/sa_result_serializer.sv
// Serializes one wide result frame of N_ELEM packed elements into OUT_W-bit
// AXI-Stream beats with TLAST. Holds one frame and accepts the next one on the final beat.
module sa_result_serializer #(
   parameter int unsigned N_ELEM = 9,
   parameter int unsigned ELEM_W = 16,
   parameter int unsigned OUT_W  = 32
) (
   input  logic                     axi_clk,
   input  logic                     axi_rst,
   input  logic                     s_axis_valid,
   input  logic [N_ELEM*ELEM_W-1:0] s_axis_data,
   output logic                     s_axis_ready,
   output logic                     m_axis_valid,
   output logic [OUT_W-1:0]         m_axis_data,
   output logic                     m_axis_last,
   input  logic                     m_axis_ready,
   output logic [15:0]              frame_count
);

   localparam int unsigned EPB    = OUT_W / ELEM_W;
   localparam int unsigned NBEATS = (N_ELEM + EPB - 1) / EPB;
   localparam int unsigned IN_W   = N_ELEM * ELEM_W;
   localparam int unsigned BUF_W  = NBEATS * OUT_W;
   localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   typedef enum logic {StIdle, StSend} state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_beat, w_beat_nxt;
   logic [BUF_W-1:0]   r_buf, w_buf_nxt;
   logic [15:0]        r_frame_cnt, w_frame_cnt_nxt;

   logic [BUF_W-1:0]   w_buf_in;
   logic [OUT_W-1:0]   w_beat_data;
   logic               w_last;
   logic               w_s_hs;

   // Zero-extending the frame makes the unused slots of the final beat read as 0.
   assign w_buf_in    = BUF_W'(s_axis_data);
   assign w_beat_data = r_buf[r_beat*OUT_W +: OUT_W];
   assign w_last      = (r_state == StSend) && (r_beat == CNT_W'(NBEATS - 1));

   assign s_axis_ready = !axi_rst && ((r_state == StIdle) || (w_last && m_axis_ready));
   assign w_s_hs       = s_axis_valid && s_axis_ready;

   assign m_axis_valid = (r_state == StSend);
   assign m_axis_data  = (r_state == StSend) ? w_beat_data : '0;
   assign m_axis_last  = w_last;
   assign frame_count  = r_frame_cnt;

   always_comb begin
      w_state_nxt     = r_state;
      w_beat_nxt      = r_beat;
      w_buf_nxt       = r_buf;
      w_frame_cnt_nxt = r_frame_cnt;
      unique case (r_state)
         StIdle: begin
            if (w_s_hs) begin
               w_buf_nxt   = w_buf_in;
               w_beat_nxt  = '0;
               w_state_nxt = StSend;
            end
         end
         StSend: begin
            if (m_axis_ready) begin
               if (w_last) begin
                  w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                  // Back-to-back frame: reload without passing through idle.
                  if (w_s_hs) begin
                     w_buf_nxt  = w_buf_in;
                     w_beat_nxt = '0;
                  end else begin
                     w_state_nxt = StIdle;
                  end
               end else begin
                  w_beat_nxt = r_beat + CNT_W'(1);
               end
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         r_state     <= StIdle;
         r_beat      <= '0;
         r_buf       <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_beat      <= w_beat_nxt;
         r_buf       <= w_buf_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
      end
   end

endmodule
